shift_operand_encoder: RTL and testbench

- Inverse of the datapath's Val2 immediate decode.
- Takes a 32-bit constant and searches for the ARM data-processing immediate encoding {rotate_imm[3:0], eight_immed[7:0]} such that value == ROR(zero-extended eight_immed, 2*rotate_imm).
- Iterative, one rotation tested per clock, with a start/done handshake.
- Used by the instruction-patch and constant-load logic to build I=1 shifter operands on-chip.

---
 rtl/shift_operand_encoder.sv | 154 +++++++++++++++
 tb/tb_shift_operand_encoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shift_operand_encoder.sv
// shift_operand_encoder
//   Finds the ARM data-processing immediate encoding {rotate_imm, eight_immed}
//   of a 32-bit constant, so that value == ROR(eight_immed, 2*rotate_imm).
//   One rotation is tested per clock. The smallest matching rotation is
//   reported, which makes the result unique.
//
// Parameters
//   MAX_ROT        highest rotate_imm tried (0..15)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          request pulse, only sampled in IDLE
//   value          constant to encode, latched on the accept edge
//   busy           high while searching
//   done           one-cycle pulse when found/shift_operand are valid
//   found          1 = encodable, 0 = not encodable within MAX_ROT
//   shift_operand  {rotate_imm, eight_immed}, 12'h000 when not found
//
// Build option
//   ENC_FAST_PATH_EN  values that already fit in 8 bits go straight to DONE
//                     on the accept edge, skipping SEARCH. The results are the
//                     same as the default build; only the latency differs.
//
// state  | meaning
// IDLE   | waiting for start; previous result held on found/shift_operand
// SEARCH | testing rotation rot_q against the latched value
// DONE   | one-cycle done pulse, then back to IDLE
module shift_operand_encoder #(
  parameter int MAX_ROT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand
);

  localparam logic [3:0] MaxRot = MAX_ROT[3:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [3:0]  rot_q, rot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [11:0] so_q, so_d;

  // Rotate left by 2*rot: the upper half of the doubled word shifted left.
  logic [5:0]  sh_amt;
  logic [63:0] dbl;
  logic [31:0] cand;
  logic        match;

  assign sh_amt = {1'b0, rot_q, 1'b0};
  assign dbl    = {val_q, val_q} << sh_amt;
  assign cand   = dbl[63:32];
  assign match  = (cand[31:8] == 24'd0);

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rot_d   = rot_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    found_d = found_q;
    so_d    = so_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          rot_d   = 4'd0;
          found_d = 1'b0;
          so_d    = 12'h000;
`ifdef ENC_FAST_PATH_EN
          if (value[31:8] == 24'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            found_d = 1'b1;
            so_d    = {4'h0, value[7:0]};
          end else begin
            state_d = SEARCH;
            busy_d  = 1'b1;
          end
`else
          state_d = SEARCH;
          busy_d  = 1'b1;
`endif
        end
      end

      SEARCH: begin
        if (match) begin
          state_d = DONE;
          done_d  = 1'b1;
          found_d = 1'b1;
          so_d    = {rot_q, cand[7:0]};
        end else if (rot_q == MaxRot) begin
          state_d = DONE;
          done_d  = 1'b1;
          found_d = 1'b0;
          so_d    = 12'h000;
        end else begin
          rot_d  = rot_q + 4'd1;
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= 32'd0;
      rot_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      so_q    <= 12'h000;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rot_q   <= rot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      so_q    <= so_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;
  assign shift_operand = so_q;

endmodule

// File: tb/tb_shift_operand_encoder.sv
// Directed bench for shift_operand_encoder; expected values are hand-computed.
module tb_shift_operand_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] shift_operand;

  int n_checks = 0;
  int n_errors = 0;

  shift_operand_encoder #(.MAX_ROT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .shift_operand (shift_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; returns edges until done is seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  function automatic int exp_latency(input logic [31:0] v, input int r);
`ifdef ENC_FAST_PATH_EN
    if (v[31:8] == 24'd0) return 0;
`endif
    return r + 1;
  endfunction

  // r is the matching rotation, or 15 when no encoding exists.
  task automatic do_req(input string tag, input logic [31:0] v, input logic exp_found,
                        input logic [11:0] exp_so, input int r);
    int lat, bcnt, elat;
    elat = exp_latency(v, r);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = $urandom;
    wait_done(lat, bcnt);
    check({tag, "_found"}, 32'(found), 32'(exp_found));
    check({tag, "_so"}, 32'(shift_operand), 32'(exp_so));
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_busy"}, 32'(bcnt), 32'(elat));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, 32'(shift_operand), 32'(exp_so));
  endtask

  initial begin
    int lat, bcnt, pulses;
    rst   = 1'b1;
    start = 1'b0;
    value = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_so", 32'(shift_operand), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    do_req("v0ff",  32'h000000FF, 1'b1, 12'h0FF, 0);
    do_req("vff0",  32'hFF000000, 1'b1, 12'h4FF, 4);
    do_req("vf0f",  32'hF000000F, 1'b1, 12'h2FF, 2);
    do_req("v3fc",  32'h000003FC, 1'b1, 12'hFFF, 15);
    do_req("v102",  32'h00000102, 1'b0, 12'h000, 15);
    do_req("vzero", 32'h00000000, 1'b1, 12'h000, 0);

    // start during SEARCH ignored; held through DONE, accepted at next IDLE edge
    start = 1'b1;
    value = 32'hFF000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    value = 32'h000000FF;
    wait_done(lat, bcnt);
    check("hs_so", 32'(shift_operand), 32'h4FF);
    check("hs_lat", 32'(lat + 1), 32'd5);
    @(posedge clk);
    #1;
    check("hs_idle_busy", 32'(busy), 32'd0);
    check("hs_idle_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("hs2_so", 32'(shift_operand), 32'h0FF);
    check("hs2_lat", 32'(lat), 32'(exp_latency(32'h000000FF, 0)));
    @(posedge clk);
    #1;

    // reset mid-SEARCH
    start = 1'b1;
    value = 32'hFF000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_found", 32'(found), 32'd0);
    check("rs_so", 32'(shift_operand), 32'd0);
    #4 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("rs_no_done", 32'(pulses), 32'd0);
    do_req("post_rst", 32'hF000000F, 1'b1, 12'h2FF, 2);

    // reset during the DONE cycle
    start = 1'b1;
    value = 32'h0000AB00;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    check("rd_pre_so", 32'(shift_operand), 32'hCAB);
    rst = 1'b1;
    #1;
    check("rd_done", 32'(done), 32'd0);
    check("rd_found", 32'(found), 32'd0);
    check("rd_so", 32'(shift_operand), 32'd0);
    #2 rst = 1'b0;
    do_req("post_rd", 32'h000000FF, 1'b1, 12'h0FF, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
